pipeline_hazard_ctl: RTL

- Central sequencer for the 3-stage pipeline (fetch/decode I, execute E, writeback W).
- Holds the PC and I/E register until program load completes.
- Detects read-after-write and load-use hazards between I and E, and issues stalls or bubbles.
- Flushes the younger stages on a taken jump, and supports debug single-step.

---
 rtl/pipeline_hazard_ctl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctl_step_edge_sync.sv | 26 ++
 rtl/pipeline_hazard_ctl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctl_pkg.sv
// Shared types for the 3-stage pipeline hazard controller (package cpu_pkg).
package cpu_pkg;

  localparam int REG_ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    WAIT_LOAD,
    RUN,
    STALL,
    FLUSH,
    STEP_WAIT
  } hz_state_t;

  typedef struct packed {
    logic pc_hold;
    logic ireg_hold;
    logic ireg_bubble;
    logic ereg_bubble;
  } hz_ctl_t;

  // Pipeline flows freely: nothing held, nothing bubbled.
  localparam hz_ctl_t CTL_NOP      = '0;
  localparam hz_ctl_t CTL_HOLD_ALL = '1;

endpackage

// File: rtl/pipeline_hazard_ctl_step_edge_sync.sv
// Debug step button synchronizer: two flops into the clock domain, then a
// one-cycle pulse on each rising edge so a held button counts once.
module step_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic step_raw,
  output logic step_pulse
);

  logic sync1, sync2, step_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      sync1     <= step_raw;
      sync2     <= sync1;
      step_prev <= sync2;
    end
  end

  assign step_pulse = sync2 & ~step_prev;

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// Central stall/flush/step sequencer for the I/E/W pipeline.
// Optional operand forwarding is built when HAZARD_FWD_EN is defined.
module pipeline_hazard_ctl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  load_done,
  input  logic [REG_ADDR_W-1:0] a_addr_I,
  input  logic [REG_ADDR_W-1:0] b_addr_I,
  input  logic                  a_use_I,
  input  logic                  b_use_I,
  input  logic [REG_ADDR_W-1:0] c_addr_E,
  input  logic                  reg_write_E,
  input  logic                  data_read_E,
  input  logic                  jump_en_W,
  input  logic                  dbg_step_en,
  input  logic                  dbg_step,
  output logic                  pc_hold,
  output logic                  ireg_hold,
  output logic                  ireg_bubble,
  output logic                  ereg_bubble,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`ifdef HAZARD_FWD_EN
  ,
  output logic                  fwd_a_sel,
  output logic                  fwd_b_sel
`endif
);

  hz_state_t state, state_d;
  hz_ctl_t   ctl;
  logic      step_pulse;
  logic      match_a, match_b, hz, stall_hz;
  logic      stall_inc, flush_inc, advance;

  step_edge_sync u_step_sync (
    .clk       (CLK),
    .rst_n     (RST_N),
    .step_raw  (dbg_step),
    .step_pulse(step_pulse)
  );

  assign match_a = a_use_I && (a_addr_I == c_addr_E);
  assign match_b = b_use_I && (b_addr_I == c_addr_E);
  assign hz      = reg_write_E && (match_a || match_b);

`ifdef HAZARD_FWD_EN
  // Only a load cannot be forwarded in time; everything else bypasses.
  assign stall_hz = hz && data_read_E;
`else
  logic [1:0] unused_fwd;
  assign unused_fwd = {data_read_E, advance};
  assign stall_hz   = hz;
`endif

  always_comb begin
    ctl       = CTL_NOP;
    state_d   = state;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    advance   = 1'b0;
    if (!load_done) begin
      ctl     = CTL_HOLD_ALL;
      state_d = WAIT_LOAD;
    end else begin
      case (state)
        WAIT_LOAD: begin
          ctl     = CTL_HOLD_ALL;
          state_d = dbg_step_en ? STEP_WAIT : RUN;
        end
        RUN, STALL: begin
          if (jump_en_W) begin
            ctl.ireg_bubble = 1'b1;
            ctl.ereg_bubble = 1'b1;
            state_d         = FLUSH;
            flush_inc       = 1'b1;
          end else if (state == RUN && stall_hz) begin
            ctl.pc_hold     = 1'b1;
            ctl.ireg_bubble = 1'b1;
            state_d         = STALL;
            stall_inc       = 1'b1;
          end else begin
            advance = 1'b1;
            state_d = (state == RUN && dbg_step_en) ? STEP_WAIT : RUN;
          end
        end
        FLUSH: begin
          ctl.ereg_bubble = 1'b1;
          state_d         = RUN;
        end
        STEP_WAIT: begin
          ctl.pc_hold     = 1'b1;
          ctl.ireg_hold   = 1'b1;
          ctl.ereg_bubble = 1'b1;
          if (!dbg_step_en || step_pulse) state_d = RUN;
        end
        default: begin
          ctl     = CTL_HOLD_ALL;
          state_d = WAIT_LOAD;
        end
      endcase
    end
  end

  assign pc_hold     = ctl.pc_hold;
  assign ireg_hold   = ctl.ireg_hold;
  assign ireg_bubble = ctl.ireg_bubble;
  assign ereg_bubble = ctl.ereg_bubble;

  // Event counters stick at all-ones and survive a reload.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= WAIT_LOAD;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_d;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

`ifdef HAZARD_FWD_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fwd_a_sel <= 1'b0;
      fwd_b_sel <= 1'b0;
    end else begin
      fwd_a_sel <= advance && reg_write_E && !data_read_E && match_a;
      fwd_b_sel <= advance && reg_write_E && !data_read_E && match_b;
    end
  end
`endif

endmodule
